vec_ldst_seq: RTL
=================

// Module: vec_ldst_seq
//
// PURPOSE
//   Vector load/store sequencer for the vector register file (VLEN-bit regs v16..v23).
//   - Vector load: reads VLEN/WORD consecutive words from data memory, assembles them
//     into one vector, then writes that vector into the register file via its write port.
//   - Vector store: captures a vector from a register file read port and writes it to memory
//     one word at a time.
//   - busy holds the pipeline in stall until the operation completes.
//
// PARAMETERS
//   VLEN    256  vector register width in bits
//   WORD    32   memory data bus width in bits; BEATS = VLEN/WORD (default 8)
//   ADDR_W  32   byte address width
//
// PORTS
//   clk        in   1       clock; all state updates on posedge
//   rst        in   1       reset; synchronous, active-high
//   start      in   1       launch operation; sampled only in IDLE
//   is_store   in   1       1 = vector store, 0 = vector load; captured at start
//   base_addr  in   ADDR_W  byte base address; captured at start
//   vreg_idx   in   5       destination vector register (load); captured at start
//   vrs_data   in   VLEN    store source vector from the regfile read port; captured at start
//   busy       out  1       high from the cycle after start until the done cycle inclusive
//   done       out  1       single-cycle completion pulse
//   mem_req    out  1       memory request valid
//   mem_we     out  1       1 = write request, 0 = read request
//   mem_addr   out  ADDR_W  word-aligned byte address of current beat
//   mem_wdata  out  WORD    store data for current beat
//   mem_gnt    in   1       memory accepted the request this cycle (mem_req & mem_gnt)
//   mem_rvalid in   1       read data valid, earliest one cycle after the granting cycle
//   mem_rdata  in   WORD    read data
//   vwe        out  1       regfile write enable
//   vwa        out  5       regfile write address
//   vwd        out  VLEN    regfile write data
//
// BEHAVIOUR
//   - Reset values: all outputs 0; state IDLE; beat counter 0; data buffer 0.
//   - States:
//     - IDLE -> REQ on start (capture operands, beat k=0).
//     - REQ: mem_req=1 held with stable addr/data until mem_gnt.
//       - Store: on gnt, next beat REQ; on gnt of the last beat, DONE.
//       - Load: on gnt, WAIT.
//     - WAIT: on mem_rvalid, latch beat k into the buffer; REQ (next beat) or WB (after the last beat).
//     - WB: vwe=1, vwa=captured idx, vwd=buffer, done=1 for one cycle -> IDLE.
//     - DONE: done=1 for one cycle -> IDLE.
//   - Only one request is outstanding at a time. No new request issues until the current one is granted (store) or its rvalid has returned (load).
//   - Beat k:
//     - mem_addr = {base_addr[ADDR_W-1:2],2'b00} + 4*k, computed modulo 2^ADDR_W, so the address wraps at the top of the space.
//     - Maps to vector bits [WORD*k +: WORD]: word 0 is the LSW.
//     - Unaligned base: low two bits dropped.
//   - mem_we equals the captured is_store whenever mem_req=1. mem_wdata = captured vrs_data[WORD*k +: WORD]; it is 0 on loads.
//   - Regfile write goes through the regfile's negedge write port. The vector is readable the cycle after WB.
//   - If the load vreg_idx is outside 16..23: all memory beats are still performed, vwe stays 0 in WB, and done still pulses.
//   - Minimum latency, start to done, when gnt and rvalid are always immediate:
//     - store: BEATS+1 cycles
//     - load: 2*BEATS+1 cycles
//   - The following are ignored:
//     - start while busy
//     - mem_gnt while mem_req=0
//     - mem_rvalid outside WAIT
//   - busy is high in REQ, WAIT, WB and DONE, and low in IDLE.
//   - rst mid-operation: IDLE on the next edge, no vwe, no done, and any in-flight read data is dropped.
//   - rst has priority over start in the same cycle.
//
// TESTING
//   1. Store, vrs_data = 0x...07_06_05_04_03_02_01_00 (word k = k), base = 0x100, gnt tied 1 ->
//      writes to 0x100..0x11C with data 0..7; done at cycle 9; busy low after.
//   2. Load to v18 from memory word k = 0xA0+k at 0x200, gnt=1, rvalid 1 cycle after gnt ->
//      a single vwe pulse with vwa=18, vwd word k = 0xA0+k, done in the same cycle.
//   3. Load with gnt delayed 3 cycles on beat 4 ->
//      mem_req/addr (0x210) held stable all 4 cycles; final vector unchanged versus test 2.
//   4. Unaligned base 0x0000_0103 and wrap base 0xFFFF_FFF8 ->
//      first addr is 0x100; addresses wrap to 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4, and so on.
//   5. Load with vreg_idx=3 -> 8 reads issued, vwe never asserts, done pulses.
//   6. Assert rst at beat 5 of a load, plus start pulses while busy ->
//      IDLE next cycle, all outputs 0, no vwe/done; extra starts have no effect.

Source files
------------

// File: rtl/vec_ldst_seq.sv
// rtl/vec_ldst_seq.sv - vector load/store sequencer between data memory and the vector register file
// One memory request outstanding at a time; loads shift words in, stores shift words out.
module vec_ldst_seq #(
  parameter int VLEN   = 256,
  parameter int WORD   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        vreg_idx,
  input  logic [VLEN-1:0]   vrs_data,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD-1:0]   mem_rdata,
  output logic              vwe,
  output logic [4:0]        vwa,
  output logic [VLEN-1:0]   vwd
);

  localparam int BEATS = VLEN / WORD;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DONE} state_t;

  state_t          state;
  logic            st;
  logic [4:0]      idx;
  logic [BW-1:0]   beat;
  logic [VLEN-1:0] sbuf;
  logic [VLEN-1:0] lbuf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      st        <= 1'b0;
      idx       <= '0;
      beat      <= '0;
      sbuf      <= '0;
      lbuf      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      vwe       <= 1'b0;
      vwa       <= '0;
      vwd       <= '0;
    end else begin
      done <= 1'b0;
      vwe  <= 1'b0;
      vwa  <= '0;
      vwd  <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= REQ;
            st        <= is_store;
            idx       <= vreg_idx;
            beat      <= '0;
            sbuf      <= vrs_data >> WORD;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {base_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= is_store ? vrs_data[WORD-1:0] : '0;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            if (!st) begin
              state   <= WAIT;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
            end else if (beat == LAST) begin
              state     <= DONE;
              done      <= 1'b1;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end else begin
              // sbuf already holds the next word at its LSW
              beat      <= beat + 1'b1;
              mem_addr  <= mem_addr + ADDR_W'(4);
              mem_wdata <= sbuf[WORD-1:0];
              sbuf      <= sbuf >> WORD;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            // words enter at the top so beat 0 ends up as the LSW
            lbuf <= {mem_rdata, lbuf[VLEN-1:WORD]};
            if (beat == LAST) begin
              state <= WB;
              done  <= 1'b1;
              vwe   <= (idx[4:3] == 2'b10);
              vwa   <= idx;
              vwd   <= {mem_rdata, lbuf[VLEN-1:WORD]};
            end else begin
              state    <= REQ;
              beat     <= beat + 1'b1;
              mem_req  <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(4);
            end
          end
        end
        WB, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
